rs_decode_ram_ctrl: RTL and testbench

//  Ring-buffer controller wrapped around the RS decoder DpRam (7-bit symbols, 143 entries).

---
 rtl/rs_decode_ram_ctrl_if.sv | 38 +++
 rtl/rs_decode_ram_ctrl.sv | 134 +++++++++++++
 tb/tb_rs_decode_ram_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_decode_ram_ctrl_if.sv
// Bus bundle between the RS decoder ring-buffer controller, its DpRam and the corrected-output datapath.
// slave = the controller, master = the parent that owns the DpRam and the decoder stages.
interface rs_decode_ram_ctrl_if #(
  parameter int SYM_W  = 7,
  parameter int ADDR_W = 8
);
  logic              enable;
  logic              sync;
  logic              in_valid;
  logic [SYM_W-1:0]  data_in;
  logic              err_start;
  logic              err_valid;
  logic [SYM_W-1:0]  err_in;
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [SYM_W-1:0]  ram_data;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [SYM_W-1:0]  ram_q;
  logic              out_valid;
  logic              out_start;
  logic              out_done;
  logic [SYM_W-1:0]  data_out;
  logic              ovf;
  logic              unf;

  modport slave (
    input  enable, sync, in_valid, data_in, err_start, err_valid, err_in, ram_q,
    output ram_wr_en, ram_wr_addr, ram_data, ram_rd_en, ram_rd_addr,
    output out_valid, out_start, out_done, data_out, ovf, unf
  );

  modport master (
    output enable, sync, in_valid, data_in, err_start, err_valid, err_in, ram_q,
    input  ram_wr_en, ram_wr_addr, ram_data, ram_rd_en, ram_rd_addr,
    input  out_valid, out_start, out_done, data_out, ovf, unf
  );
endinterface

// File: rtl/rs_decode_ram_ctrl.sv
// Ring-buffer controller around the RS decoder DpRam: stores received symbols, reads them back
// in order aligned with the Chien/Forney error magnitudes, and emits XOR-corrected symbols.
module rs_decode_ram_ctrl #(
  parameter int SYM_W  = 7,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 143,
  parameter int CW_LEN = 127
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rs_decode_ram_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(CW_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CW_LEN - 1);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] fifo_q [2];
  logic              fifo_rd_q, fifo_wr_q;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx1_q, idx2_q;
  logic              v1_q, v2_q;
  logic [SYM_W-1:0]  err1_q, err2_q;
  logic              out_valid_q, out_start_q, out_done_q, ovf_q, unf_q;
  logic [SYM_W-1:0]  data_out_q;
  logic              wr, wr_drop, rd, rd_dec, pop, push_req, push, push_drop, unf_set;

  function automatic logic [ADDR_W-1:0] inc_wrap(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign wr        = bus.enable & bus.in_valid & (count_q != FULL_CNT);
  assign wr_drop   = bus.enable & bus.in_valid & (count_q == FULL_CNT);
  assign rd        = bus.enable & bus.err_valid;
  assign rd_dec    = rd & (count_q != '0);
  assign pop       = rd & bus.err_start & (fifo_cnt_q != 2'd0);
  assign push_req  = wr & bus.sync;
  // A full FIFO can still accept a push in the cycle its head is popped.
  assign push      = push_req & ((fifo_cnt_q != 2'd2) | pop);
  assign push_drop = push_req & ~push;
  assign rd_addr   = pop ? fifo_q[fifo_rd_q] : rd_ptr_q;
  assign unf_set   = rd & ((count_q == '0) | (bus.err_start & (fifo_cnt_q == 2'd0)));

  always_comb begin
    count_d = count_q;
    if (wr & ~rd_dec)      count_d = count_q + 1'b1;
    else if (~wr & rd_dec) count_d = count_q - 1'b1;
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push & ~pop)      fifo_cnt_d = fifo_cnt_q + 2'd1;
    else if (~push & pop) fifo_cnt_d = fifo_cnt_q - 2'd1;
  end

  always_comb begin
    idx_d = idx_q;
    if (rd) begin
      if (bus.err_start)        idx_d = '0;
      else if (idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= '0;
      idx_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (wr) wr_ptr_q <= inc_wrap(wr_ptr_q);
      if (rd) rd_ptr_q <= inc_wrap(rd_addr);
      count_q    <= count_d;
      fifo_cnt_q <= fifo_cnt_d;
      idx_q      <= idx_d;
      if (push) begin
        fifo_q[fifo_wr_q] <= wr_ptr_q;
        fifo_wr_q         <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      if (wr_drop | push_drop) ovf_q <= 1'b1;
      if (unf_set)             unf_q <= 1'b1;
    end
  end

  // Two delay stages match the DpRam read latency; they advance regardless of enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      err1_q      <= '0;
      err2_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      out_valid_q <= 1'b0;
      out_start_q <= 1'b0;
      out_done_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      v1_q        <= rd;
      err1_q      <= bus.err_in;
      idx1_q      <= idx_d;
      v2_q        <= v1_q;
      err2_q      <= err1_q;
      idx2_q      <= idx1_q;
      out_valid_q <= v2_q;
      out_start_q <= v2_q & (idx2_q == '0);
      out_done_q  <= v2_q & (idx2_q == LAST_IDX);
      if (v2_q) data_out_q <= bus.ram_q ^ err2_q;
    end
  end

  assign bus.ram_wr_en   = wr;
  assign bus.ram_wr_addr = wr_ptr_q;
  assign bus.ram_data    = bus.data_in;
  assign bus.ram_rd_en   = rd;
  assign bus.ram_rd_addr = rd_addr;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_start   = out_start_q;
  assign bus.out_done    = out_done_q;
  assign bus.data_out    = data_out_q;
  assign bus.ovf         = ovf_q;
  assign bus.unf         = unf_q;
endmodule

// File: tb/tb_rs_decode_ram_ctrl.sv
// Scoreboard bench for rs_decode_ram_ctrl with a 2-cycle-latency DpRam model.
module tb_rs_decode_ram_ctrl;
  localparam int SYM_W = 7, ADDR_W = 8, DEPTH = 143, CW_LEN = 127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_decode_ram_ctrl_if #(.SYM_W(SYM_W), .ADDR_W(ADDR_W)) bus ();

  rs_decode_ram_ctrl #(.SYM_W(SYM_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CW_LEN(CW_LEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  logic [SYM_W-1:0] mem [256];
  logic [SYM_W-1:0] q1;
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_data;
    if (bus.ram_rd_en) q1 <= mem[bus.ram_rd_addr];
    bus.ram_q <= q1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SYM_W-1:0] data;
    logic start, done, chk_data, chk_flags;
    int   cyc;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data 0x%0h with no expected entry at cycle %0d", bus.data_out, cyc);
      end else begin
        e = sbq.pop_front();
        check("out_latency", cyc, e.cyc + 3);
        if (e.chk_data) check("data_out", int'(bus.data_out), int'(e.data));
        if (e.chk_flags) begin
          check("out_start", int'(bus.out_start), int'(e.start));
          check("out_done", int'(bus.out_done), int'(e.done));
        end
      end
    end else if (rst_n) begin
      check("flags_idle", int'(bus.out_start | bus.out_done), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.in_valid  = 1'b0;
    bus.sync      = 1'b0;
    bus.data_in   = '0;
    bus.err_valid = 1'b0;
    bus.err_start = 1'b0;
    bus.err_in    = '0;
  endtask

  task automatic set_wr(input logic [SYM_W-1:0] d, input logic s);
    bus.enable   = 1'b1;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.sync     = s;
  endtask

  task automatic set_rd(input logic st, input logic [SYM_W-1:0] ei, input logic [SYM_W-1:0] d,
                        input logic s, input logic dn, input logic cd, input logic cf);
    exp_t e;
    bus.enable    = 1'b1;
    bus.err_valid = 1'b1;
    bus.err_start = st;
    bus.err_in    = ei;
    e.data = d; e.start = s; e.done = dn; e.chk_data = cd; e.chk_flags = cf; e.cyc = cyc;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    clr();
    bus.enable = 1'b1;
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    clr();
    repeat (6) tick();
    check(name, sbq.size(), 0);
  endtask

  task automatic write_cw(input logic rev);
    for (int i = 0; i < CW_LEN; i++) begin
      clr();
      set_wr(rev ? 7'(CW_LEN - i) : 7'(i + 1), i == 0);
      tick();
    end
    clr();
  endtask

  task automatic read_cw(input int err_idx, input logic [SYM_W-1:0] err_val);
    logic [SYM_W-1:0] ev;
    for (int i = 0; i < CW_LEN; i++) begin
      clr();
      ev = (i == err_idx) ? err_val : '0;
      set_rd(i == 0, ev, 7'(i + 1) ^ ev, i == 0, i == CW_LEN - 1, 1'b1, 1'b1);
      tick();
    end
    clr();
  endtask

  initial begin
    clr();
    bus.enable = 1'b0;
    do_reset();
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_count", int'(dut.count_q), 0);
    check("rst_wr_ptr", int'(dut.wr_ptr_q), 0);
    check("rst_rd_ptr", int'(dut.rd_ptr_q), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    check("rst_unf", int'(bus.unf), 0);

    // enable low blocks writes
    bus.enable = 1'b0; bus.in_valid = 1'b1; #1;
    check("en_gate_wr", int'(bus.ram_wr_en), 0);
    tick(); clr(); bus.enable = 1'b1;
    check("en_gate_count", int'(dut.count_q), 0);

    // clean codeword
    write_cw(1'b0);
    check("cw1_count", int'(dut.count_q), CW_LEN);
    read_cw(-1, '0);
    drain("cw1_drain");

    // single error at index 10
    write_cw(1'b0);
    read_cw(10, 7'h55);
    drain("cw2_drain");

    // prefill/drain then wrap-straddling codeword
    do_reset();
    for (int i = 0; i < 100; i++) begin clr(); set_wr(7'(i), 1'b0); tick(); end
    for (int i = 0; i < 100; i++) begin clr(); set_rd(1'b0, '0, 7'(i), 1'b0, 1'b0, 1'b1, 1'b0); tick(); end
    drain("prefill_drain");
    check("prefill_count", int'(dut.count_q), 0);
    for (int i = 0; i < CW_LEN; i++) begin
      clr();
      set_wr(7'(i + 1), i == 0);
      #1 check("wrap_wr_addr", int'(bus.ram_wr_addr), (100 + i) % DEPTH);
      tick();
    end
    read_cw(-1, '0);
    drain("wrap_drain");
    check("wrap_ovf", int'(bus.ovf), 0);
    check("wrap_unf", int'(bus.unf), 0);

    // fill to full then one more
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin clr(); set_wr(7'(i), 1'b0); tick(); end
    clr();
    check("full_count", int'(dut.count_q), DEPTH);
    check("full_ovf_pre", int'(bus.ovf), 0);
    set_wr(7'h2A, 1'b0);
    #1 check("full_wr_en", int'(bus.ram_wr_en), 0);
    tick(); clr();
    check("full_ovf", int'(bus.ovf), 1);
    check("full_count_hold", int'(dut.count_q), DEPTH);
    check("full_wr_ptr_hold", int'(dut.wr_ptr_q), 0);

    // back-to-back codewords with overlap; #2 errStart reloads from start FIFO
    do_reset();
    write_cw(1'b0);
    for (int i = 0; i < 120; i++) begin
      clr();
      set_wr(7'(CW_LEN - i), i == 0);
      set_rd(i == 0, '0, 7'(i + 1), i == 0, 1'b0, 1'b1, 1'b1);
      tick();
      check("overlap_count", int'(dut.count_q), CW_LEN);
    end
    for (int i = 120; i < CW_LEN; i++) begin clr(); set_wr(7'(CW_LEN - i), 1'b0); tick(); end
    clr();
    check("overlap_count_end", int'(dut.count_q), CW_LEN + 7);
    for (int i = 0; i < CW_LEN; i++) begin
      clr();
      set_rd(i == 0, '0, 7'(CW_LEN - i), i == 0, i == CW_LEN - 1, 1'b1, 1'b1);
      if (i == 0) begin #1 check("reload_rd_addr", int'(bus.ram_rd_addr), CW_LEN); end
      tick();
    end
    drain("b2b_drain");
    check("b2b_count", int'(dut.count_q), 7);
    check("b2b_unf", int'(bus.unf), 0);

    // underflow, then reset mid-readout, then a fresh codeword
    do_reset();
    set_rd(1'b1, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); clr();
    check("unf_set", int'(bus.unf), 1);
    drain("unf_drain");
    write_cw(1'b0);
    for (int i = 0; i < 50; i++) begin
      clr();
      set_rd(i == 0, '0, 7'(i + 1), i == 0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    clr();
    rst_n = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_count", int'(dut.count_q), 0);
    check("midrst_wr_ptr", int'(dut.wr_ptr_q), 0);
    check("midrst_rd_ptr", int'(dut.rd_ptr_q), 0);
    check("midrst_unf", int'(bus.unf), 0);
    check("midrst_ovf", int'(bus.ovf), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    write_cw(1'b0);
    read_cw(-1, '0);
    drain("fresh_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
